// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, AXI responses and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data, misalignment flag, load extension.
// Purely combinational; no flow control.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [2:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] wdata_lane,
  output logic              misalign,
  output logic [DATA_W-1:0] ld_data
);

  localparam int OFF_W = $clog2(STRB_W);

  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] smask;
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] keep;
  logic              sign;

  assign off = addr_lo[OFF_W-1:0];

  always_comb begin
    smask    = '0;
    keep     = '0;
    sign     = 1'b0;
    misalign = 1'b0;
    rshift   = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin
        smask = STRB_W'(1);
        keep  = DATA_W'(8'hFF);
        sign  = rshift[7];
      end
      SZ_HALF: begin
        smask    = STRB_W'(2'b11);
        keep     = DATA_W'(16'hFFFF);
        sign     = rshift[15];
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        smask    = STRB_W'(4'hF);
        keep     = DATA_W'(32'hFFFF_FFFF);
        sign     = rshift[31];
        misalign = |addr_lo[1:0];
      end
      default: begin
        // A doubleword cannot be carried by a 32-bit bus, so it always errors there.
        smask    = '1;
        keep     = '1;
        sign     = rshift[DATA_W-1];
        misalign = (DATA_W == 32) ? 1'b1 : |addr_lo;
      end
    endcase
    wstrb      = smask << off;
    wdata_lane = wdata << {off, 3'b000};
    ld_data    = (rshift & keep) | ((sign && !unsigned_ld) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_axil_master.sv
// Memory-stage load/store unit: one request in, at most one AXI4-Lite access, one registered result out.
// Load latency 3 cycles with a zero-wait slave; result held until write-back takes it.
module lsu_axil_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  lsu_state_t state;

  logic [1:0] size_q;
  logic       uns_q;
  logic [2:0] addr_lo_q;

  logic              is_idle;
  logic [1:0]        a_size;
  logic              a_uns;
  logic [2:0]        a_addr_lo;
  logic [STRB_W-1:0] a_wstrb;
  logic [DATA_W-1:0] a_wdata;
  logic              a_misalign;
  logic [DATA_W-1:0] a_ld_data;
  logic              aw_pending;
  logic              w_pending;

  // In IDLE the aligner sees the live request; afterwards it sees the captured one for load extension.
  assign is_idle   = (state == IDLE);
  assign a_size    = is_idle ? size : size_q;
  assign a_uns     = is_idle ? unsigned_ld : uns_q;
  assign a_addr_lo = is_idle ? addr[2:0] : addr_lo_q;

  assign aw_pending = m_awvalid && !m_awready;
  assign w_pending  = m_wvalid && !m_wready;

  lsu_align #(
    .DATA_W(DATA_W),
    .STRB_W(STRB_W)
  ) u_align (
    .size       (a_size),
    .unsigned_ld(a_uns),
    .addr_lo    (a_addr_lo),
    .wdata      (wdata),
    .rdata      (m_rdata),
    .wstrb      (a_wstrb),
    .wdata_lane (a_wdata),
    .misalign   (a_misalign),
    .ld_data    (a_ld_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            size_q    <= size;
            uns_q     <= unsigned_ld;
            addr_lo_q <= addr[2:0];
            result    <= '0;
            err       <= 1'b0;
            // Alignment only matters for real memory ops; ALU ops carry arbitrary addr values.
            if ((mem_read || mem_write) && a_misalign) begin
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (mem_read) begin
              m_araddr  <= addr;
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end else if (mem_write) begin
              m_awaddr  <= addr;
              m_wdata   <= a_wdata;
              m_wstrb   <= a_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            err       <= (m_rresp != RESP_OKAY);
            result    <= (m_rresp != RESP_OKAY) ? '0 : a_ld_data;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        WR: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready) m_wvalid <= 1'b0;
          if (!aw_pending && !w_pending) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            err       <= (m_bresp != RESP_OKAY);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master at DATA_W=32 and DATA_W=64 with a result scoreboard.
module tb_lsu_axil_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // shared request fields and write-back ready
  logic        mem_read, mem_write, unsigned_ld, out_ready;
  logic [1:0]  size;
  logic [31:0] addr;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, err;
  logic [31:0] wdata, result;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  // 64-bit instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_err;
  logic [63:0] w_wdata, w_result, w_rdata, w_mwdata;
  logic [31:0] w_araddr, w_awaddr;
  logic        w_arvalid, w_arready, w_rvalid, w_rready;
  logic        w_awvalid, w_awready, w_wvalid, w_wready, w_bvalid, w_bready;
  logic [1:0]  w_rresp, w_bresp;
  logic [7:0]  w_wstrb;

  lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  lsu_axil_master #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(w_wdata), .out_valid(w_out_valid), .out_ready(out_ready),
    .result(w_result), .err(w_err),
    .m_araddr(w_araddr), .m_arvalid(w_arvalid), .m_arready(w_arready),
    .m_rdata(w_rdata), .m_rresp(w_rresp), .m_rvalid(w_rvalid), .m_rready(w_rready),
    .m_awaddr(w_awaddr), .m_awvalid(w_awvalid), .m_awready(w_awready),
    .m_wdata(w_mwdata), .m_wstrb(w_wstrb), .m_wvalid(w_wvalid), .m_wready(w_wready),
    .m_bresp(w_bresp), .m_bvalid(w_bvalid), .m_bready(w_bready)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request for a single accept cycle and pushes its expected result.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [63:0] wd, input bit wide,
                       input logic [63:0] exp_res, input logic exp_err);
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    unsigned_ld = uns;
    addr        = a;
    wdata       = wd[31:0];
    w_wdata     = wd;
    if (wide) w_in_valid = 1'b1;
    else in_valid = 1'b1;
    chk("in_ready_idle", 64'(wide ? w_in_ready : in_ready), 64'd1);
    sb.push_back('{res: exp_res, err: exp_err});
    tick();
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    cyc        = 1;
    chk("in_ready_busy", 64'(wide ? w_in_ready : in_ready), 64'd0);
  endtask

  task automatic rd_resp32(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] resp);
    chk("arvalid", 64'(m_arvalid), 64'd1);
    chk("araddr", 64'(m_araddr), 64'(a));
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("ar_drop", 64'(m_arvalid), 64'd0);
    chk("rready", 64'(m_rready), 64'd1);
    m_rvalid = 1'b1;
    m_rdata  = rd;
    m_rresp  = resp;
    tick();
    m_rvalid = 1'b0;
    chk("rready_drop", 64'(m_rready), 64'd0);
  endtask

  task automatic rd_resp64(input logic [31:0] a, input logic [63:0] rd, input logic [1:0] resp);
    chk("arvalid64", 64'(w_arvalid), 64'd1);
    chk("araddr64", 64'(w_araddr), 64'(a));
    w_arready = 1'b1;
    tick();
    w_arready = 1'b0;
    chk("rready64", 64'(w_rready), 64'd1);
    w_rvalid = 1'b1;
    w_rdata  = rd;
    w_rresp  = resp;
    tick();
    w_rvalid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, compares with the scoreboard, optionally stalls, then retires.
  task automatic expect_out(input int lat_exp, input int hold, input bit wide);
    exp_t e;
    bit   seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wide ? w_out_valid : out_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("out_valid_seen", 64'(seen), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (!seen) return;
    chk("result", wide ? w_result : 64'(result), e.res);
    chk("err", 64'(wide ? w_err : err), 64'(e.err));
    chk("latency", 64'(cyc), 64'(lat_exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(wide ? w_out_valid : out_valid), 64'd1);
      chk("hold_result", wide ? w_result : 64'(result), e.res);
      chk("hold_in_ready", 64'(wide ? w_in_ready : in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(wide ? w_out_valid : out_valid), 64'd0);
    chk("in_ready_back", 64'(wide ? w_in_ready : in_ready), 64'd1);
  endtask

  task automatic check_idle32(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_valids"}, 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; size = SZ_WORD; unsigned_ld = 1'b0;
    addr = '0; wdata = '0; w_wdata = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = RESP_OKAY;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
    w_arready = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_rresp = RESP_OKAY;
    w_awready = 1'b0; w_wready = 1'b0; w_bvalid = 1'b0; w_bresp = RESP_OKAY;
    tick();
    tick();
    check_idle32("reset");
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset64_in_ready", 64'(w_in_ready), 64'd1);
    resetn = 1'b1;
    tick();

    // signed byte load from the top lane
    issue(1, 0, SZ_BYTE, 0, 32'h8000_0003, 64'd0, 0, 64'hFFFF_FF80, 0);
    rd_resp32(32'h8000_0003, 32'h80FF_1234, RESP_OKAY);
    expect_out(3, 0, 0);

    // half loads, unsigned then signed, from the upper half
    issue(1, 0, SZ_HALF, 1, 32'h8000_0002, 64'd0, 0, 64'h0000_BEEF, 0);
    rd_resp32(32'h8000_0002, 32'hBEEF_1234, RESP_OKAY);
    expect_out(3, 0, 0);
    issue(1, 0, SZ_HALF, 0, 32'h8000_0002, 64'd0, 0, 64'hFFFF_BEEF, 0);
    rd_resp32(32'h8000_0002, 32'hBEEF_1234, RESP_OKAY);
    expect_out(3, 0, 0);
    issue(1, 0, SZ_WORD, 0, 32'h8000_0004, 64'd0, 0, 64'h1234_5678, 0);
    rd_resp32(32'h8000_0004, 32'h1234_5678, RESP_OKAY);
    expect_out(3, 0, 0);

    // store half: AW taken two cycles before W
    issue(0, 1, SZ_HALF, 0, 32'h8000_0002, 64'h0000_ABCD, 0, 64'd0, 0);
    chk("st_awvalid", 64'(m_awvalid), 64'd1);
    chk("st_wvalid", 64'(m_wvalid), 64'd1);
    chk("st_awaddr", 64'(m_awaddr), 64'h8000_0002);
    chk("st_wstrb", 64'(m_wstrb), 64'b1100);
    chk("st_wdata", 64'(m_wdata), 64'hABCD_0000);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    chk("st_aw_drop", 64'(m_awvalid), 64'd0);
    chk("st_w_held", 64'(m_wvalid), 64'd1);
    tick();
    chk("st_no_bready", 64'(m_bready), 64'd0);
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    chk("st_w_drop", 64'(m_wvalid), 64'd0);
    chk("st_bready", 64'(m_bready), 64'd1);
    chk("st_no_early_out", 64'(out_valid), 64'd0);
    m_bvalid = 1'b1;
    m_bresp  = RESP_OKAY;
    tick();
    m_bvalid = 1'b0;
    chk("st_bready_drop", 64'(m_bready), 64'd0);
    expect_out(5, 0, 0);

    // store byte with AW and W in the same cycle, DECERR response
    issue(0, 1, SZ_BYTE, 0, 32'h8000_0011, 64'h0000_005A, 0, 64'd0, 1);
    chk("sb_wstrb", 64'(m_wstrb), 64'b0010);
    chk("sb_wdata", 64'(m_wdata), 64'h0000_5A00);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    tick();
    m_awready = 1'b0;
    m_wready  = 1'b0;
    chk("sb_valids_drop", 64'({m_awvalid, m_wvalid}), 64'd0);
    chk("sb_bready", 64'(m_bready), 64'd1);
    m_bvalid = 1'b1;
    m_bresp  = RESP_DECERR;
    tick();
    m_bvalid = 1'b0;
    m_bresp  = RESP_OKAY;
    expect_out(3, 0, 0);

    // misaligned accesses never reach the bus
    issue(1, 0, SZ_WORD, 0, 32'h8000_0001, 64'd0, 0, 64'd0, 1);
    chk("mis_no_ar", 64'(m_arvalid), 64'd0);
    expect_out(1, 0, 0);
    issue(1, 0, SZ_DWORD, 0, 32'h8000_0000, 64'd0, 0, 64'd0, 1);
    chk("dw32_no_ar", 64'(m_arvalid), 64'd0);
    expect_out(1, 0, 0);
    issue(0, 1, SZ_HALF, 0, 32'h8000_0001, 64'h1234, 0, 64'd0, 1);
    chk("mis_no_aw", 64'({m_awvalid, m_wvalid}), 64'd0);
    expect_out(1, 0, 0);

    // load bus error, then write-back stalls four cycles
    issue(1, 0, SZ_WORD, 0, 32'h8000_0008, 64'd0, 0, 64'd0, 1);
    rd_resp32(32'h8000_0008, 32'hDEAD_BEEF, RESP_SLVERR);
    expect_out(3, 4, 0);

    // reset while waiting for read data
    mem_read = 1'b1; mem_write = 1'b0; size = SZ_WORD; addr = 32'h8000_0010;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("rst_in_rd_data", 64'(m_rready), 64'd1);
    resetn = 1'b0;
    tick();
    check_idle32("midrst");
    resetn = 1'b1;
    issue(0, 0, SZ_WORD, 0, 32'h8000_0000, 64'd0, 0, 64'd0, 0);
    expect_out(1, 0, 0);

    // 64-bit datapath
    issue(1, 0, SZ_DWORD, 1, 32'h8000_0008, 64'd0, 1, 64'h0123_4567_89AB_CDEF, 0);
    rd_resp64(32'h8000_0008, 64'h0123_4567_89AB_CDEF, RESP_OKAY);
    expect_out(3, 0, 1);
    issue(1, 0, SZ_WORD, 1, 32'h8000_0004, 64'd0, 1, 64'h0000_0000_F000_0000, 0);
    rd_resp64(32'h8000_0004, 64'hF000_0000_0000_0000, RESP_OKAY);
    expect_out(3, 0, 1);
    issue(1, 0, SZ_WORD, 0, 32'h8000_0004, 64'd0, 1, 64'hFFFF_FFFF_F000_0000, 0);
    rd_resp64(32'h8000_0004, 64'hF000_0000_0000_0000, RESP_OKAY);
    expect_out(3, 0, 1);
    issue(1, 0, SZ_BYTE, 0, 32'h8000_0003, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
    rd_resp64(32'h8000_0003, 64'h0000_0000_80FF_1234, RESP_OKAY);
    expect_out(3, 0, 1);
    issue(0, 1, SZ_HALF, 0, 32'h8000_0006, 64'h0000_0000_0000_ABCD, 1, 64'd0, 0);
    chk("st64_wstrb", 64'(w_wstrb), 64'hC0);
    chk("st64_wdata", w_mwdata, 64'hABCD_0000_0000_0000);
    w_awready = 1'b1;
    w_wready  = 1'b1;
    tick();
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b1;
    tick();
    w_bvalid = 1'b0;
    expect_out(3, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
